// File: rtl/spram_fifo_ctrl_pkg.sv
// Shared constants and RAM operation encoding for the single-port-RAM FIFO controller.
package spram_fifo_ctrl_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 2;
    localparam int LVL_W_DEF  = 3;

    typedef enum logic [1:0] {
        OP_IDLE = 2'd0,
        OP_WR   = 2'd1,
        OP_RD   = 2'd2
    } ram_op_e;

endpackage

// File: rtl/spram_fifo_ctrl_if.sv
// Push/pop valid-ready stream bundle between the pipeline and the FIFO controller.
interface spram_fifo_ctrl_if #(
    parameter int DATA_W = spram_fifo_ctrl_pkg::DATA_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/spram_fifo_obuf.sv
// Two-entry in-order output buffer fed by RAM read captures and drained by the consumer.
module spram_fifo_obuf #(
    parameter int DATA_W = spram_fifo_ctrl_pkg::DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        cnt_o
);

    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              pop;

    assign pop = pop_i & (cnt_q != 2'd0);

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case ({push_i, pop})
            2'b10: begin
                if (cnt_q != 2'd2) begin
                    if (cnt_q == 2'd0) head_d = push_data_i;
                    else               tail_d = push_data_i;
                    cnt_d = cnt_q + 2'd1;
                end
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                // Simultaneous capture and pop: count holds, order is kept.
                if (cnt_q == 2'd1) begin
                    head_d = push_data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) begin
            // NOTE: the two data words are reset too, so out_data reads 0 out of reset.
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign valid_o = (cnt_q != 2'd0);
    assign data_o  = head_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/spram_fifo_ctrl.sv
// FIFO built on one single-port RAM: arbitrates push writes against pop-prefetch reads, one op per cycle.
module spram_fifo_ctrl
    import spram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 2 ** ADDR_W,
    parameter int LVL_W  = LVL_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    spram_fifo_ctrl_if.slave  s_if,
    output logic              ram_ena,
    output logic              ram_wea,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    input  logic              ram_read_valid,
    output logic [LVL_W-1:0]  level,
    output logic              full,
    output logic              empty
);

    localparam int            CW      = ADDR_W + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     ram_cnt_q, ram_cnt_d;
    logic              rd_inflight_q, rd_inflight_d;
    logic              prio_q, prio_d;

    logic [1:0]        ob_cnt;
    logic              ob_valid;
    logic [DATA_W-1:0] ob_data;

    logic    pop_now, capture, space;
    logic    wr_want, rd_want, wr_grant, rd_grant;
    ram_op_e op;

    assign pop_now = ob_valid & s_if.out_ready;
    assign capture = rd_inflight_q & ram_read_valid;
    // rst_n gates space so nothing is accepted or written while reset is held.
    assign space   = rst_n & (ram_cnt_q < CNT_MAX);
    assign wr_want = s_if.in_valid & space;
    assign rd_want = (ram_cnt_q != '0) &&
                     (({1'b0, ob_cnt} + {2'b00, rd_inflight_q}) < (3'd2 + {2'b00, pop_now}));

    // in_ready is built only from state and rd_want, never from in_valid.
    assign s_if.in_ready = space & ~(rd_want & prio_q);
    assign wr_grant      = wr_want & ~(rd_want & prio_q);
    assign rd_grant      = rd_want & ~(wr_want & ~prio_q);

    always_comb begin
        op = OP_IDLE;
        if (wr_grant)      op = OP_WR;
        else if (rd_grant) op = OP_RD;
    end

    always_comb begin
        ram_ena  = 1'b0;
        ram_wea  = 1'b0;
        ram_addr = '0;
        case (op)
            OP_WR: begin
                ram_ena  = 1'b1;
                ram_wea  = 1'b1;
                ram_addr = wr_ptr_q;
            end
            OP_RD: begin
                ram_ena  = 1'b1;
                ram_addr = rd_ptr_q;
            end
            default: ;
        endcase
    end

    assign ram_din = s_if.in_data;

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        ram_cnt_d     = ram_cnt_q;
        rd_inflight_d = rd_inflight_q;
        prio_d        = prio_q;
        if (op == OP_WR) begin
            wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
            ram_cnt_d = ram_cnt_q + CW'(1);
        end
        if (op == OP_RD) begin
            rd_ptr_d      = rd_ptr_q + ADDR_W'(1);
            ram_cnt_d     = ram_cnt_q - CW'(1);
            rd_inflight_d = 1'b1;
        end else if (capture) begin
            rd_inflight_d = 1'b0;
        end
        // A conflict hands priority to the loser, so contention strictly alternates.
        if (wr_want && rd_want) prio_d = ~prio_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            ram_cnt_q     <= '0;
            rd_inflight_q <= 1'b0;
            prio_q        <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            ram_cnt_q     <= ram_cnt_d;
            rd_inflight_q <= rd_inflight_d;
            prio_q        <= prio_d;
        end
    end

    spram_fifo_obuf #(.DATA_W(DATA_W)) u_obuf (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (capture),
        .push_data_i (ram_dout),
        .pop_i       (s_if.out_ready),
        .valid_o     (ob_valid),
        .data_o      (ob_data),
        .cnt_o       (ob_cnt)
    );

    assign s_if.out_valid = ob_valid;
    assign s_if.out_data  = ob_data;

    assign level = LVL_W'(ram_cnt_q) + LVL_W'(rd_inflight_q) + LVL_W'(ob_cnt);
    assign full  = (ram_cnt_q == CNT_MAX);
    assign empty = (level == '0);

endmodule
